csa_tree_pipe: RTL and testbench

CSA_TREE_PIPE -- requirements
Module: csa_tree_pipe

---
 rtl/csa_tree_pipe_pkg.sv | 41 ++++
 rtl/csa_tree_pipe_csa32.sv | 18 +
 rtl/csa_tree_pipe.sv | 107 ++++++++++
 tb/tb_csa_tree_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/csa_tree_pipe_pkg.sv
// Shared elaboration helpers for the pipelined carry-save adder tree:
// width math, per-level row counts and parameter range checks.
package csa_tree_pipe_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        int unsigned p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Rows remaining after lv levels of 3:2 compression starting from n rows.
    function automatic int unsigned rows_after(input int unsigned n, input int unsigned lv);
        int unsigned r = n;
        for (int unsigned i = 0; i < lv; i++)
            r = 2 * (r / 3) + (r % 3);
        return r;
    endfunction

    function automatic int unsigned num_levels(input int unsigned n);
        int unsigned r = n;
        int unsigned lv = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + (r % 3);
            lv = lv + 1;
        end
        return lv;
    endfunction

    function automatic bit w_legal(input int unsigned w);
        return (w >= 2) && (w <= 32);
    endfunction

    function automatic bit n_legal(input int unsigned n);
        return (n >= 3) && (n <= 8);
    endfunction

endpackage

// File: rtl/csa_tree_pipe_csa32.sv
// Combinational 3:2 compressor: three rows in, sum row and shifted carry row out.
module csa32 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    // The carry out of the top bit falls off the shift (modulo 2^W).
    always_comb begin
        s  = a ^ b ^ c;
        co = ((a & b) | (a & c) | (b & c)) << 1;
    end

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined N-operand adder: one registered 3:2 level per stage, then a
// registered carry-propagate add into Y. Operands are sign/zero-extended on entry.
module csa_tree_pipe
    import csa_tree_pipe_pkg::*;
#(
    parameter int unsigned W = 6,
    parameter int unsigned N = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      in_valid,
    input  logic                      signed_mode,
    input  logic [N*W-1:0]            ops,
    output logic                      out_valid,
    output logic [W+clog2(N)-1:0]     Y
);

    localparam int unsigned OW = W + clog2(N);
    localparam int unsigned LV = num_levels(N);

    if (!w_legal(W)) begin : g_bad_w
        $error("csa_tree_pipe: W out of range 2..32");
    end
    if (!n_legal(N)) begin : g_bad_n
        $error("csa_tree_pipe: N out of range 3..8");
    end

    logic [N-1:0][OW-1:0] ext;

    always_comb begin
        ext = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (signed_mode)
                ext[k] = OW'(signed'(ops[k*W +: W]));
            else
                ext[k] = OW'(ops[k*W +: W]);
        end
    end

    // Each level is sized exactly to its row count; it reads the previous
    // level's registers through the generate hierarchy.
    for (genvar l = 1; l <= LV; l++) begin : g_lvl
        localparam int unsigned RI = rows_after(N, l - 1);
        localparam int unsigned RO = rows_after(N, l);
        localparam int unsigned G  = RI / 3;
        localparam int unsigned LO = RI % 3;

        logic [RI-1:0][OW-1:0] din;
        logic [RO-1:0][OW-1:0] nxt;
        logic [RO-1:0][OW-1:0] q;
        logic                  vin;
        logic                  vq;

        if (l == 1) begin : g_src
            assign din = ext;
            assign vin = in_valid;
        end else begin : g_src
            assign din = g_lvl[l-1].q;
            assign vin = g_lvl[l-1].vq;
        end

        for (genvar k = 0; k < G; k++) begin : g_csa
            csa32 #(.W(OW)) u_csa (
                .a  (din[3*k]),
                .b  (din[3*k+1]),
                .c  (din[3*k+2]),
                .s  (nxt[2*k]),
                .co (nxt[2*k+1])
            );
        end

        for (genvar j = 0; j < LO; j++) begin : g_pass
            assign nxt[2*G+j] = din[3*G+j];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q  <= '0;
                vq <= 1'b0;
            end else if (ce) begin
                q  <= nxt;
                vq <= vin;
            end
        end
    end

    logic [OW-1:0] row_a;
    logic [OW-1:0] row_b;
    logic          last_v;

    assign row_a  = g_lvl[LV].q[0];
    assign row_b  = g_lvl[LV].q[1];
    assign last_v = g_lvl[LV].vq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y         <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= last_v;
            if (last_v)
                Y <= row_a + row_b;
        end
    end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Scoreboard bench for csa_tree_pipe: a W=6/N=4 and a W=6/N=8 instance share
// clock, reset, ce and signed_mode; each has its own operands and valid.
module tb_csa_tree_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b0;
    logic        sgn = 1'b0;
    logic        iv4 = 1'b0;
    logic        iv8 = 1'b0;
    logic [23:0] ops4 = '0;
    logic [47:0] ops8 = '0;
    logic        ov4;
    logic        ov8;
    logic [7:0]  y4;
    logic [8:0]  y8;

    always #5 clk = ~clk;

    csa_tree_pipe #(.W(6), .N(4)) dut4 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(iv4), .signed_mode(sgn),
        .ops(ops4), .out_valid(ov4), .Y(y4)
    );

    csa_tree_pipe #(.W(6), .N(8)) dut8 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(iv8), .signed_mode(sgn),
        .ops(ops8), .out_valid(ov8), .Y(y8)
    );

    typedef struct {
        logic [8:0] y;
        int         due;
    } exp_t;

    exp_t       q4[$];
    exp_t       q8[$];
    int         adv    = 0;
    int         errors = 0;
    int         checks = 0;
    logic [8:0] ly4 = '0;
    logic [8:0] ly8 = '0;
    logic       eo4 = 1'b0;
    logic       eo8 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: extend each 6-bit operand, sum as integers, wrap to ow bits.
    function automatic logic [8:0] model(input logic [47:0] ops, input int n,
                                         input logic s, input int ow);
        int acc = 0;
        for (int k = 0; k < n; k++) begin
            logic [5:0] v;
            int         x;
            v = ops[k*6 +: 6];
            x = int'(v);
            if (s && v[5]) x -= 64;
            acc += x;
        end
        return 9'(acc & ((1 << ow) - 1));
    endfunction

    task automatic cycle();
        logic advd;
        exp_t e;
        @(posedge clk);
        advd = ce && !rst;
        if (advd) begin
            adv++;
            if (iv4) begin
                e.y = model({24'd0, ops4}, 4, sgn, 8);
                e.due = adv + 2;
                q4.push_back(e);
            end
            if (iv8) begin
                e.y = model(ops8, 8, sgn, 9);
                e.due = adv + 4;
                q8.push_back(e);
            end
        end
        @(negedge clk);
        if (advd) begin
            eo4 = 1'b0;
            if (q4.size() > 0 && q4[0].due == adv) begin
                e = q4.pop_front();
                eo4 = 1'b1;
                ly4 = e.y;
            end
            eo8 = 1'b0;
            if (q8.size() > 0 && q8[0].due == adv) begin
                e = q8.pop_front();
                eo8 = 1'b1;
                ly8 = e.y;
            end
        end
        check("ov4", 32'(ov4), 32'(eo4));
        check("y4",  32'(y4),  32'(ly4));
        check("ov8", 32'(ov8), 32'(eo8));
        check("y8",  32'(y8),  32'(ly8));
    endtask

    task automatic idle(input int n);
        iv4 = 1'b0;
        iv8 = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set4(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                        input logic [5:0] d, input logic s);
        ops4 = {d, c, b, a};
        sgn  = s;
        iv4  = 1'b1;
        iv8  = 1'b0;
        cycle();
    endtask

    // Reset is raised mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ov4", 32'(ov4), 32'd0);
        check("rst_y4",  32'(y4),  32'd0);
        check("rst_ov8", 32'(ov8), 32'd0);
        check("rst_y8",  32'(y8),  32'd0);
        q4.delete();
        q8.delete();
        eo4 = 1'b0;
        eo8 = 1'b0;
        ly4 = '0;
        ly8 = '0;
    endtask

    initial begin
        #1;
        do_reset();
        idle(2);
        rst = 1'b0;
        ce  = 1'b1;
        idle(1);

        // all 63 unsigned -> 252, then signed extremes
        set4(6'd63, 6'd63, 6'd63, 6'd63, 1'b0);
        idle(4);
        set4(6'h20, 6'h20, 6'h20, 6'h20, 1'b1);
        set4(6'd31, 6'h3f, 6'h3f, 6'd1, 1'b1);
        idle(4);

        // back-to-back stream
        set4(6'd1, 6'd2, 6'd3, 6'd4, 1'b0);
        set4(6'd5, 6'd5, 6'd5, 6'd5, 1'b0);
        set4(6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
        set4(6'd63, 6'd0, 6'd0, 6'd1, 1'b0);
        idle(4);

        // ce stall with a result sitting in the output stage
        set4(6'd7, 6'd8, 6'd9, 6'd10, 1'b0);
        set4(6'd11, 6'd12, 6'd13, 6'd14, 1'b0);
        set4(6'd40, 6'd41, 6'd42, 6'd43, 1'b0);
        ce = 1'b0;
        ops4 = {4{6'd33}};
        cycle();
        cycle();
        ce = 1'b1;
        idle(4);

        // reset with two sets in flight
        set4(6'd2, 6'd2, 6'd2, 6'd2, 1'b0);
        set4(6'd3, 6'd3, 6'd3, 6'd3, 1'b0);
        iv4 = 1'b0;
        do_reset();
        idle(2);
        rst = 1'b0;
        idle(5);
        set4(6'd9, 6'd9, 6'd9, 6'd9, 1'b0);
        idle(4);

        // N=8 instance: all 63 unsigned -> 504, then a signed set
        ops8 = {8{6'd63}};
        sgn  = 1'b0;
        iv8  = 1'b1;
        cycle();
        ops8 = {6'h20, 6'd31, 6'h3f, 6'd5, 6'h2a, 6'd17, 6'h20, 6'd0};
        sgn  = 1'b1;
        cycle();
        idle(6);

        // random traffic with bubbles and stalls
        for (int i = 0; i < 60; i++) begin
            ops4 = 24'($urandom);
            ops8 = {16'($urandom), 32'($urandom)};
            sgn  = 1'($urandom);
            iv4  = ($urandom_range(0, 3) != 0);
            iv8  = ($urandom_range(0, 3) != 0);
            ce   = ($urandom_range(0, 4) != 0);
            cycle();
        end
        ce = 1'b1;
        idle(8);
        check("q4_drained", 32'(q4.size()), 32'd0);
        check("q8_drained", 32'(q8.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
